sample_recorder: RTL

Captures 8-bit offset-binary audio samples into an internal buffer at the sample-rate strobe, then plays them back on the same strobe. Acts as the write-side counterpart of the ROM-based drum sample players. Sits between the audio input path and the mixer/PWM output, driven by the shared 8 kHz enable. Record, playback and stop are single-cycle command pulses.

---
 rtl/sample_recorder.sv | 114 +++++++++++
 1 files changed

// File: rtl/sample_recorder.sv
// Sample buffer: records din on each en strobe, plays back on the same strobe; SAMPLE_RECORDER_LOOP_EN enables looped playback.
// Commands act on the edge that samples them, dout one cycle after en; no backpressure, strobes are never stalled.
module sample_recorder #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rec,
  input  logic          play,
  input  logic          stop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          recording,
  output logic          playing,
  output logic          full,
  output logic [AW:0]   len
);

  typedef enum logic [1:0] {IDLE, RECORD, PLAYBACK} state_t;

  localparam logic [DW-1:0] SILENCE  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [AW:0]   LAST_LEN = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   FULL_LEN = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic cmd_rec, rd_end, wr_en, pb_step, play_ok;

  assign cmd_rec = rec & ~stop;
  assign rd_end  = (rd_ptr >= len);
  assign wr_en   = (state == RECORD) & en & ~stop & ~rec;
  assign pb_step = (state == PLAYBACK) & en & ~stop & ~rec & ~play;
  assign play_ok = play & ~stop & ~rec &
                   ((state == PLAYBACK) | ((state == IDLE) & (len != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_rec)      state_nxt = RECORD;
        else if (play_ok) state_nxt = PLAYBACK;
      end
      RECORD: begin
        if (stop)                           state_nxt = IDLE;
        else if (rec)                       state_nxt = RECORD;
        else if (en && (len == LAST_LEN))   state_nxt = IDLE;
      end
      PLAYBACK: begin
        if (stop)     state_nxt = IDLE;
        else if (rec) state_nxt = RECORD;
`ifndef SAMPLE_RECORDER_LOOP_EN
        else if (pb_step && rd_end) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    recording = (state == RECORD);
    playing   = (state == PLAYBACK);
  end

  assign full = (len == FULL_LEN);

  // Buffer contents deliberately survive reset; len alone gates what is reachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= SILENCE;
      len    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (cmd_rec) begin
      dout   <= SILENCE;
      len    <= '0;
      wr_ptr <= '0;
    end else if (stop) begin
      dout <= SILENCE;
    end else if (play_ok) begin
      rd_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      len    <= len + 1'b1;
    end else if (pb_step) begin
      if (!rd_end) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
`ifdef SAMPLE_RECORDER_LOOP_EN
        dout   <= mem[0];
        rd_ptr <= (AW+1)'(1);
`else
        dout   <= SILENCE;
`endif
      end
    end
  end

endmodule
